// File: rtl/me_fetch_ctrl_if.sv
// Handshake and memory bus bundle for the motion-estimation row fetcher.
interface me_fetch_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [ADDR_W-1:0] stride_i;
    logic              busy_o;
    logic              done_o;
    logic              mem_rd_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [183:0]      mem_data_i;
    logic              row_valid_o;
    logic [183:0]      row_data_o;
    logic              row_ready_i;
    logic [7:0]        row_idx_o;

    modport slave (
        input  start_i, base_addr_i, stride_i, mem_data_i, row_ready_i,
        output busy_o, done_o, mem_rd_en_o, mem_addr_o,
        output row_valid_o, row_data_o, row_idx_o
    );

    modport master (
        output start_i, base_addr_i, stride_i, mem_data_i, row_ready_i,
        input  busy_o, done_o, mem_rd_en_o, mem_addr_o,
        input  row_valid_o, row_data_o, row_idx_o
    );
endinterface

// File: rtl/me_fetch_ctrl.sv
// Fetches ROWS strided rows from a 1-cycle-latency memory into a
// 2-entry in-order buffer feeding the downstream split stage.
module me_fetch_ctrl #(
    parameter int ADDR_W = 10,
    parameter int ROWS   = 16
) (
    input logic          clk_i,
    input logic          rst_n_i,
    me_fetch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] stride_q;
    logic [7:0]        issued;
    logic [7:0]        ret_idx;
    logic              infl;
    logic              head;
    logic [1:0]        occ;
    logic              busy_q;
    logic              done_q;
    logic [183:0]      buf_data [2];
    logic [7:0]        buf_idx  [2];

    logic              pop;
    logic              push;
    logic              rd_en;
    logic              last_issue;
    logic              last_pop;
    logic              wr_slot;
    logic [2:0]        pending;

    always_comb begin
        pop        = (occ != 2'd0) && bus.row_ready_i;
        push       = infl;
        // buffered + in flight, less what leaves this cycle
        pending    = ({1'b0, occ} + {2'b0, infl}) - {2'b0, pop};
        rd_en      = (state == FETCH) && (pending < 3'd2);
        last_issue = rd_en && (issued == 8'(ROWS - 1));
        last_pop   = pop && (buf_idx[head] == 8'(ROWS - 1));
        wr_slot    = head ^ occ[0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            issued   <= '0;
            ret_idx  <= '0;
            infl     <= 1'b0;
            head     <= 1'b0;
            occ      <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            infl   <= rd_en;
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        addr_q   <= bus.base_addr_i;
                        stride_q <= bus.stride_i;
                        issued   <= '0;
                        ret_idx  <= '0;
                        busy_q   <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (rd_en) begin
                        addr_q <= addr_q + stride_q;
                        issued <= issued + 8'd1;
                        if (last_issue) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: state <= IDLE;
            endcase
            if (push) ret_idx <= ret_idx + 8'd1;
            if (pop) head <= ~head;
            occ <= (occ + {1'b0, push}) - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_data[wr_slot] <= bus.mem_data_i;
            buf_idx[wr_slot]  <= ret_idx;
        end
    end

    always_comb begin
        bus.busy_o      = busy_q;
        bus.done_o      = done_q;
        bus.mem_rd_en_o = rd_en;
        bus.mem_addr_o  = rd_en ? addr_q : '0;
        bus.row_valid_o = (occ != 2'd0);
        bus.row_data_o  = (occ != 2'd0) ? buf_data[head] : '0;
        bus.row_idx_o   = (occ != 2'd0) ? buf_idx[head] : '0;
    end
endmodule
